// File: rtl/counter_16_if.sv
// counter_16_if: groups the fetch-side load/increment controls and the
// counter output of the 16-bit program counter.
//   d_in  - parallel load value (jump target)
//   load  - capture d_in on the next rising edge
//   inc   - add one on the next rising edge
//   d_out - current counter value (register output)
// master: the controller driving load/inc/d_in and reading d_out.
// slave : the counter itself.
interface counter_16_if;
  logic [15:0] d_in;
  logic        load;
  logic        inc;
  logic [15:0] d_out;

  modport master (output d_in, output load, output inc, input d_out);
  modport slave  (input d_in, input load, input inc, output d_out);
endinterface

// File: rtl/counter_16.sv
// counter_16: 16-bit loadable program counter.
// Priority on each rising edge: reset (async, active low) > load > inc > hold.
// d_out comes straight from the state register; there is no combinational
// path from any input to the output.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low clear
//   bus   - counter_16_if.slave (d_in, load, inc, d_out)
// Build option: define COUNTER_16_SAT_EN to make the increment saturate at
// 0xFFFF instead of wrapping to 0x0000. Load and reset are unaffected.
module counter_16 (
  input  logic          clk,
  input  logic          reset,
  counter_16_if.slave   bus
);

  logic [15:0] count;
  logic [15:0] count_inc;

`ifdef COUNTER_16_SAT_EN
  // Hold at all-ones rather than rolling over.
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
`else
  assign count_inc = count + 16'd1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        count <= 16'h0000;
    else if (bus.load) count <= bus.d_in;   // jump wins over increment
    else if (bus.inc)  count <= count_inc;
  end

  assign bus.d_out = count;

endmodule

// File: tb/tb_counter_16.sv
// tb_counter_16: directed-vector bench for counter_16.
module tb_counter_16;

  logic clk;
  logic reset;
  counter_16_if bus ();

  counter_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic in, input logic [15:0] d);
    bus.load = ld;
    bus.inc  = in;
    bus.d_in = d;
  endtask

  logic [15:0] wrap1, wrap2;

  initial begin
`ifdef COUNTER_16_SAT_EN
    wrap1 = 16'hFFFF; wrap2 = 16'hFFFF;
`else
    wrap1 = 16'h0000; wrap2 = 16'h0001;
`endif
    // Reset held low with load and inc active: output pinned at zero.
    reset = 1'b0;
    drive(1'b1, 1'b1, 16'h1234);
    #2;
    chk("reset_val", bus.d_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", bus.d_out, 16'h0000);
    end

    // Release with load pending: first edge applies the load.
    drive(1'b1, 1'b0, 16'h0042);
    reset = 1'b1;
    step();
    chk("release_load", bus.d_out, 16'h0042);

    // Bring count to zero, then increment run.
    drive(1'b1, 1'b0, 16'h0000);
    step();
    chk("load_zero", bus.d_out, 16'h0000);
    drive(1'b0, 1'b1, 16'h0000);
    step(); chk("inc_1", bus.d_out, 16'h0001);
    step(); chk("inc_2", bus.d_out, 16'h0002);
    step(); chk("inc_3", bus.d_out, 16'h0003);
    drive(1'b0, 1'b0, 16'h0000);
    step(); chk("hold_3a", bus.d_out, 16'h0003);
    step(); chk("hold_3b", bus.d_out, 16'h0003);

    // Up to 5, then asynchronous clear between edges.
    drive(1'b0, 1'b1, 16'h0000);
    step(); chk("inc_4", bus.d_out, 16'h0004);
    step(); chk("inc_5", bus.d_out, 16'h0005);
    drive(1'b0, 1'b0, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    chk("async_clr", bus.d_out, 16'h0000);
    drive(1'b0, 1'b1, 16'h0000);
    step();
    chk("clr_hold", bus.d_out, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);
    reset = 1'b1;

    // Load beats increment.
    drive(1'b1, 1'b1, 16'h0080);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_prio", bus.d_out, 16'h0080);
    end
    drive(1'b0, 1'b1, 16'h0080);
    step(); chk("inc_81", bus.d_out, 16'h0081);
    step(); chk("inc_82", bus.d_out, 16'h0082);

    // Load then idle; d_in changes ignored without load.
    drive(1'b1, 1'b0, 16'h0080);
    step(); chk("ld_80", bus.d_out, 16'h0080);
    drive(1'b0, 1'b0, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_80", bus.d_out, 16'h0080);
    end

    // Top of range.
    drive(1'b1, 1'b0, 16'hFFFF);
    step(); chk("ld_ffff", bus.d_out, 16'hFFFF);
    drive(1'b0, 1'b1, 16'h0000);
    step(); chk("wrap_1", bus.d_out, wrap1);
    step(); chk("wrap_2", bus.d_out, wrap2);

    // Load of 0xFFFF accepted again from any state.
    drive(1'b1, 1'b1, 16'hFFFF);
    step(); chk("reld_ffff", bus.d_out, 16'hFFFF);

    // Reset in the cycle of a load aborts the load.
    drive(1'b1, 1'b0, 16'h1111);
    reset = 1'b0;
    step();
    chk("rst_vs_load", bus.d_out, 16'h0000);
    reset = 1'b1;
    step();
    chk("post_rst_load", bus.d_out, 16'h1111);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_16.md
# counter_16

16-bit loadable program counter with increment, parallel load and asynchronous clear. Supplies the instruction address to the CPU fetch path: it advances by one per cycle, is overwritten on jumps, and clears on reset. Single clock domain, one register stage, no handshake.

## Interface
Parameters:
- none (width fixed at 16 bits)

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset
- reset  input  1  asynchronous, active-low reset; 0 clears the counter immediately
- d_in  input  16  parallel load value (jump target)
- load  input  1  active-high; capture d_in on next rising edge
- inc  input  1  active-high; add 1 on next rising edge
- d_out  output  16  current counter value, driven directly from the register

## Operation
- One 16-bit state register `count`; d_out = count at all times, with no combinational path from any input to d_out.
- Per-edge priority, highest first:
  - reset low -> count = 0x0000
  - load high -> count = d_in
  - inc high -> count = count + 1
  - otherwise hold
- load and inc both high: load wins, and the increment is discarded for that cycle.
- Arithmetic is unsigned modulo 2^16. Increment at 0xFFFF gives 0x0000 in the default build (see Configuration).
- d_in is sampled only on an edge where load is high; otherwise it is ignored.
- Unknown or X inputs get no special handling.

## Timing
- Reset value: d_out = 0x0000.
- Reset assertion is asynchronous: d_out goes to 0x0000 without waiting for clk, and stays there as long as reset is low, whatever load and inc are doing.
- Reset release is synchronous in effect: the first rising edge with reset high applies load/inc normally. Inputs present at the release edge are honoured.
- Reset mid-operation (during a run of increments or in the cycle of a load) aborts that update; the counter reads 0 afterwards.
- Latency is one cycle: a value captured or incremented at edge N is visible on d_out right after edge N and holds until edge N+1.
- Throughput is one increment per clock; consecutive increments give N, N+1, N+2, …
- Sustained load with a constant d_in holds d_out at d_in.

## Configuration
- Macro COUNTER_16_SAT_EN.
- Undefined (default): increment wraps, so 0xFFFF + inc -> 0x0000.
- Defined: increment saturates, so 0xFFFF + inc -> 0xFFFF, with d_out holding.
- load and reset behave the same in both builds. A load of any value, including 0xFFFF, is always accepted.

## Test plan
- Reset and hold: hold reset low, toggle clk with load=1, d_in=0x1234 and inc=1 -> d_out stays 0x0000. Then pull reset low asynchronously between edges while d_out=0x0005 -> d_out=0x0000 before the next edge.
- Increment run: reset high, count=0, inc=1 for 3 edges -> d_out reads 0x0001, 0x0002, 0x0003. Drop inc -> value holds at 0x0003 over further edges.
- Load priority: d_in=0x0080, load=1, inc=1 for 3 edges -> d_out=0x0080 after every edge, with no 0x0081. Then load=0, inc=1 -> 0x0081, 0x0082.
- Load then idle: load 0x0080, then load=0, inc=0 for 3 edges -> d_out stays 0x0080. A d_in change to 0xBEEF with load=0 -> no effect.
- Wrap/saturate: load 0xFFFF, then inc=1 for one edge -> d_out=0x0000 (default), or d_out=0xFFFF with COUNTER_16_SAT_EN defined.
- Reset release: release reset with load=1, d_in=0x0042 -> the first edge after release gives d_out=0x0042.
